// File: rtl/tpg_pkg.sv
// tpg_pkg: shared state type, default mode range and mode stepping for the TPG sequencer
package tpg_pkg;
  localparam int MODE_W = 4;
  localparam int MODE_MIN_DEF = 1;
  localparam int MODE_MAX_DEF = 11;
  typedef enum logic [1:0] {WAIT_LOCK, RUN, PEND} tpg_state_t;
  function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m, input int lo, input int hi);
    return (m == MODE_W'(hi)) ? MODE_W'(lo) : m + MODE_W'(1);
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronise a raw button and accept a new level only after it holds steady
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic PXLCLK_I,
  input  logic RSTN_I,
  input  logic BTN_I,
  output logic LEVEL_O,
  output logic RISE_O
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s0, s1, flip;
  logic [CW-1:0] cnt;
  always_comb flip = s1 != LEVEL_O && cnt == CW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge PXLCLK_I)
    if (!RSTN_I) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      cnt <= '0;
      LEVEL_O <= 1'b0;
      RISE_O <= 1'b0;
    end else begin
      s0 <= BTN_I;
      s1 <= s0;
      cnt <= (s1 == LEVEL_O || flip) ? '0 : cnt + CW'(1);
      LEVEL_O <= LEVEL_O ^ flip;
      RISE_O <= flip & s1;
    end
endmodule

// File: rtl/tpg_mode_sequencer.sv
// tpg_mode_sequencer: steps the test-pattern mode on frame starts, by button or every N frames
module tpg_mode_sequencer
  import tpg_pkg::*;
#(
  parameter int   MODE_MIN        = MODE_MIN_DEF,
  parameter int   MODE_MAX        = MODE_MAX_DEF,
  parameter int   FRAMES_PER_MODE = 120,
  parameter int   DEBOUNCE_CYCLES = 250000,
  parameter logic VS_POL          = 1'b0
) (
  input  logic              PXLCLK_I,
  input  logic              RSTN_I,
  input  logic              LOCKED_I,
  input  logic              VS_I,
  input  logic              BTN_NEXT_I,
  input  logic              AUTO_EN_I,
  output logic [MODE_W-1:0] TPG_MODE_O,
  output logic              MODE_CHG_O,
  output logic              FRAME_LED_O
);
  localparam int FW = $clog2(FRAMES_PER_MODE + 1);
  tpg_state_t st;
  logic vs_d, pend_btn, btn_lvl, btn_rise;
  logic fs, run, auto_req, btn_req, req, apply, fclr;
  logic [FW-1:0] fcnt;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .PXLCLK_I(PXLCLK_I),
    .RSTN_I  (RSTN_I),
    .BTN_I   (BTN_NEXT_I),
    .LEVEL_O (btn_lvl),
    .RISE_O  (btn_rise)
  );
  always_comb begin
    fs = VS_I == VS_POL && vs_d != VS_POL;
    run = st != WAIT_LOCK;
    auto_req = fs && run && AUTO_EN_I && fcnt == FW'(FRAMES_PER_MODE - 1);
    btn_req = btn_rise & btn_lvl;
    req = auto_req | btn_req;
    apply = fs && st == PEND;
    fclr = !AUTO_EN_I || auto_req || (apply && pend_btn);
  end
  // a request seen on the applying fs re-arms PEND so it lands on the next frame
  always_ff @(posedge PXLCLK_I)
    if (!RSTN_I) begin
      st <= WAIT_LOCK;
      TPG_MODE_O <= MODE_W'(MODE_MIN);
      MODE_CHG_O <= 1'b0;
      FRAME_LED_O <= 1'b0;
      fcnt <= '0;
      pend_btn <= 1'b0;
      vs_d <= 1'b0;
    end else if (!LOCKED_I) begin
      st <= WAIT_LOCK;
      TPG_MODE_O <= MODE_W'(MODE_MIN);
      MODE_CHG_O <= 1'b0;
      fcnt <= '0;
      pend_btn <= 1'b0;
      vs_d <= VS_I;
    end else begin
      st <= !run ? RUN : req ? PEND : apply ? RUN : st;
      TPG_MODE_O <= apply ? next_mode(TPG_MODE_O, MODE_MIN, MODE_MAX) : TPG_MODE_O;
      MODE_CHG_O <= apply;
      FRAME_LED_O <= FRAME_LED_O ^ (fs && run);
      fcnt <= fclr ? '0 : fcnt + FW'(fs && run);
      pend_btn <= run && (btn_req || (pend_btn && !apply));
      vs_d <= VS_I;
    end
endmodule
